display_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 8-digit seven-segment display. It holds a 32-bit display word (8 hex nibbles) and steps a 3-bit digit select through digits 0..7 at a fixed refresh rate. Each step presents the matching nibble to the hex-to-segment/anode decoder directly downstream. Display updates are applied only at frame boundaries to avoid tearing, and the block supports per-digit masking and leading-zero blanking.

---
 rtl/display_scan_ctrl.sv | 113 +++++++++++
 tb/tb_display_scan_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Steps the digit select at a fixed rate; new display words take effect only at frame boundaries.
module display_scan_ctrl #(
  parameter int TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value_in,
  input  logic [7:0]  digit_en_in,
  input  logic        blank_lz,
  output logic [3:0]  hex_out,
  output logic [2:0]  digit_sel,
  output logic        blank_out,
  output logic        pend,
  output logic        frame_done
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]       digit_sel_q, digit_sel_d;
  logic [31:0]      val_p_q, val_p_d, val_a_q, val_a_d;
  logic [7:0]       en_p_q, en_p_d, en_a_q, en_a_d;
  logic             lz_p_q, lz_p_d, lz_a_q, lz_a_d;
  logic             pend_q, pend_d;
  logic             frame_done_q, frame_done_d;
  logic             tick, wrap;

  assign tick = (tick_cnt_q == TICK_MAX);
  assign wrap = tick && (digit_sel_q == 3'd7);

  always_comb begin
    tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
    digit_sel_d  = tick ? digit_sel_q + 3'd1 : digit_sel_q;
    frame_done_d = wrap;
    val_p_d      = val_p_q;
    en_p_d       = en_p_q;
    lz_p_d       = lz_p_q;
    val_a_d      = val_a_q;
    en_a_d       = en_a_q;
    lz_a_d       = lz_a_q;
    pend_d       = pend_q;
    if (load && !wrap) begin
      val_p_d = value_in;
      en_p_d  = digit_en_in;
      lz_p_d  = blank_lz;
      pend_d  = 1'b1;
    end else if (wrap) begin
      // A load landing on the boundary bypasses the pending set entirely.
      if (load) begin
        val_a_d = value_in;
        en_a_d  = digit_en_in;
        lz_a_d  = blank_lz;
      end else if (pend_q) begin
        val_a_d = val_p_q;
        en_a_d  = en_p_q;
        lz_a_d  = lz_p_q;
      end
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q   <= '0;
      digit_sel_q  <= 3'd0;
      val_p_q      <= 32'd0;
      en_p_q       <= 8'hFF;
      lz_p_q       <= 1'b0;
      val_a_q      <= 32'd0;
      en_a_q       <= 8'hFF;
      lz_a_q       <= 1'b0;
      pend_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      digit_sel_q  <= digit_sel_d;
      val_p_q      <= val_p_d;
      en_p_q       <= en_p_d;
      lz_p_q       <= lz_p_d;
      val_a_q      <= val_a_d;
      en_a_q       <= en_a_d;
      lz_a_q       <= lz_a_d;
      pend_q       <= pend_d;
      frame_done_q <= frame_done_d;
    end
  end

  // zero_from[k] is set when nibbles k..7 of the active word are all zero.
  logic [3:0] nib [8];
  logic [8:0] zero_from;
  assign zero_from[8] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      assign nib[gi]       = val_a_q[4*gi +: 4];
      assign zero_from[gi] = (nib[gi] == 4'd0) && zero_from[gi+1];
    end
  endgenerate

  logic lz_hit;
  assign lz_hit = lz_a_q && (digit_sel_q != 3'd0) && zero_from[digit_sel_q];

  assign hex_out    = nib[digit_sel_q];
  assign digit_sel  = digit_sel_q;
  assign blank_out  = !en_a_q[digit_sel_q] || lz_hit;
  assign pend       = pend_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with TICK_DIV = 4 (one frame = 32 cycles).
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] value_in = 32'd0;
  logic [7:0]  digit_en_in = 8'hFF;
  logic        blank_lz = 1'b0;
  logic [3:0]  hex_out;
  logic [2:0]  digit_sel;
  logic        blank_out;
  logic        pend;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int p     = 0;  // cycles since reset release

  display_scan_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in),
    .digit_en_in(digit_en_in), .blank_lz(blank_lz), .hex_out(hex_out),
    .digit_sel(digit_sel), .blank_out(blank_out), .pend(pend),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, p);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    p++;
  endtask

  task automatic go_to(input int ph);
    int n = 0;
    while ((p % 32) != ph && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    p = 0;
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] en, input logic lz);
    value_in = v; digit_en_in = en; blank_lz = lz; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Idle display of all zeros: checks the select sequence and frame pulses cycle by cycle.
  task automatic free_run(input int n);
    for (int i = 0; i <= n; i++) begin
      chk("sel", digit_sel, 32'((p / 4) % 8));
      chk("frame_done", frame_done, (p > 0 && p % 32 == 0) ? 1 : 0);
      chk("hex_idle", hex_out, 0);
      chk("blank_idle", blank_out, 0);
      chk("pend_idle", pend, 0);
      if (i < n) step();
    end
  endtask

  // Walks one frame, checking start and end of each digit's hold window.
  task automatic check_frame(input string tag, input logic [31:0] val, input logic [7:0] blk);
    for (int d = 0; d < 8; d++) begin
      for (int k = 0; k < 4; k += 3) begin
        go_to(4 * d + k);
        chk({tag, "_sel"}, digit_sel, d);
        chk({tag, "_hex"}, hex_out, val[4*d +: 4]);
        chk({tag, "_blank"}, blank_out, blk[d]);
      end
    end
    $display("frame %s val=%08h blank=%02h checked", tag, val, blk);
  endtask

  initial begin
    step();
    do_reset();
    chk("rst_sel", digit_sel, 0);
    chk("rst_hex", hex_out, 0);
    chk("rst_blank", blank_out, 0);
    chk("rst_pend", pend, 0);
    chk("rst_fd", frame_done, 0);

    // 1: free run two frames
    free_run(64);
    $display("free run 64 cycles done");

    // 2: load during digit 3, applied at next boundary
    go_to(12);
    do_load(32'h12345678, 8'hFF, 1'b0);
    chk("ld_pend", pend, 1);
    chk("ld_hex_hold", hex_out, 0);
    go_to(31);
    chk("pre_wrap_hex", hex_out, 0);
    chk("pre_wrap_pend", pend, 1);
    step();
    chk("wrap_fd", frame_done, 1);
    chk("wrap_pend", pend, 0);
    check_frame("s2", 32'h12345678, 8'h00);

    // 3: last load wins; load on wrap bypasses pending
    go_to(4);
    do_load(32'hAAAAAAAA, 8'hFF, 1'b0);
    go_to(10);
    do_load(32'hBBBBBBBB, 8'hFF, 1'b0);
    chk("two_ld_pend", pend, 1);
    chk("two_ld_hex", hex_out, 4'h8 - 4'(p / 4 % 8));
    go_to(0);
    check_frame("s3b", 32'hBBBBBBBB, 8'h00);
    go_to(31);
    chk("byp_pre_pend", pend, 0);
    do_load(32'hCCCCCCCC, 8'hFF, 1'b0);
    chk("byp_pend", pend, 0);
    chk("byp_fd", frame_done, 1);
    check_frame("s3c", 32'hCCCCCCCC, 8'h00);
    chk("byp_pend_end", pend, 0);

    // 4: leading-zero blanking
    go_to(8);
    do_load(32'h00000A05, 8'hFF, 1'b1);
    go_to(0);
    check_frame("lz1", 32'h00000A05, 8'hF8);
    go_to(8);
    do_load(32'h00000000, 8'hFF, 1'b1);
    go_to(0);
    check_frame("lz0", 32'h00000000, 8'hFE);

    // 5: per-digit enable mask
    go_to(8);
    do_load(32'h87654321, 8'h0F, 1'b0);
    go_to(0);
    check_frame("en", 32'h87654321, 8'hF0);

    // 6: reset between load and wrap discards everything
    go_to(20);
    do_load(32'hDEADBEEF, 8'h00, 1'b1);
    chk("pre_rst_pend", pend, 1);
    go_to(26);
    do_reset();
    free_run(40);
    $display("reset mid-frame checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
